regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Shares the single write port of the 4×16-bit register file between two write-back requesters, such as ALU results and load data. Each requester gets a one-entry buffer with a valid/ready handshake. A round-robin arbiter that respects write age drains the buffers into registered `RegWrite`/`WR`/`WD` outputs, one write per cycle. A `pending` scoreboard tells the control unit which registers still have writes in flight, so it can stall dependent reads.

## Interface
- `DATA_WIDTH`, default 16: write data width; must match the register file.
- `ADDR_WIDTH`, default 2: register address width; `NREGS = 2**ADDR_WIDTH`.

Ports:
- `clock`  in  1: rising-edge clock.
- `reset_n`  in  1: reset, asynchronous and active-low.
- `req0_valid`  in  1: requester 0 offers a write.
- `req0_wr`  in  ADDR_WIDTH: requester 0 target register.
- `req0_wd`  in  DATA_WIDTH: requester 0 write data.
- `req0_ready`  out  1: requester 0 buffer can accept.
- `req1_valid`  in  1: requester 1 offers a write.
- `req1_wr`  in  ADDR_WIDTH: requester 1 target register.
- `req1_wd`  in  DATA_WIDTH: requester 1 write data.
- `req1_ready`  out  1: requester 1 buffer can accept.
- `RegWrite`  out  1: register file write enable (registered).
- `WR`  out  ADDR_WIDTH: register file write address (registered).
- `WD`  out  DATA_WIDTH: register file write data (registered).
- `grant`  out  2: one-hot source of the current `RegWrite` cycle; 00 when idle.
- `pending`  out  NREGS: bit i set while any accepted write to register i has not yet been captured by the register file.

## Operation
- **Accept:**
  - A transfer occurs on a rising edge where `reqN_valid && reqN_ready`.
  - The buffer captures `wr`, `wd` and an age stamp.
- **Ready:**
  - `reqN_ready` = buffer N empty OR buffer N drains this cycle.
  - Ready depends on registered state only, never on `valid` (no combinational loop).
- **Drain selection**, evaluated each cycle on buffer occupancy:
  - Neither buffer occupied: no drain.
  - One occupied: drain it.
  - Both occupied, same `wr`: drain the older entry.
    - Entries accepted on the same edge count req0 as older.
  - Both occupied, different `wr`: drain the buffer the round-robin pointer favours. The pointer then points at the other requester.
  - The pointer moves only when the drain was a real contest, so a lone requester keeps its fairness slot.
- **Output stage:**
  - On a drain edge: `RegWrite`=1, `WR`/`WD` = drained entry, `grant` = its one-hot.
  - On a non-drain edge: `RegWrite`=0 and `grant`=00. `WR`/`WD` hold their last values.
- **Pending:**
  - Built from the decoded `wr` of each occupied buffer.
  - OR'd with the decoded `WR` while `RegWrite`=1.
- **Simultaneous events:** a buffer may drain and accept a new entry on the same edge. Throughput is one write per cycle per requester while the other is idle.
- **Bandwidth:** combined sustained rate is 1 write/cycle. Under contention each requester gets every other cycle.

## Timing
- **Reset (async assert, sync release):**
  - Buffers empty, pointer favours req0.
  - `RegWrite`=0, `WR`=0, `WD`=0, `grant`=00, `pending`=0.
  - `req0_ready`=`req1_ready`=0 while `reset_n` is low, then 1 on the first cycle after release.
- **Latency, uncontended:**
  - Accept at edge N.
  - `RegWrite` high during cycle N+1 to N+2.
  - Register file captures at edge N+2; `pending` bit clears after edge N+2.
- **Contended:** the loser's issue slips by exactly one cycle per competing write ahead of it.
- **Reset mid-operation:**
  - Buffered and in-flight writes are discarded.
  - `RegWrite` falls immediately on `reset_n` low; no partial write issues after release.
- **Ordering:** writes to the same register from the same requester are always issued in acceptance order.

## Test plan
1. **Reset:** assert `reset_n`=0 mid-stream with both buffers full. Outputs go to the reset values above asynchronously. After release the first cycle shows `ready`=1 and `pending`=0.
2. **Single write:** req0 writes `WR`=01, `WD`=AAAA at edge N. `RegWrite`=1, `WR`=01, `WD`=AAAA, `grant`=01 during N+1. `pending`=0010 from N to N+2, then 0000.
3. **Contention, different registers:** req0 (10, 5555) and req1 (11, 1234) accepted on the same edge. req0 issues first, then req1. A repeat on the next pair issues req1 first (pointer toggled).
4. **Same-register age:**
   - req1 (01, BEEF) accepted one cycle before req0 (01, CAFE), with both buffered: BEEF issues before CAFE.
   - Both accepted on the same edge: req0 issues first.
5. **Streaming:** req1 holds valid for 8 cycles with req0 idle. 8 writes on 8 consecutive cycles, `req1_ready` stays 1, `grant`=10 throughout.
6. **Backpressure:** both requesters hold valid continuously. Each `ready` drops every other cycle, issues alternate 01/10, and no write is lost or duplicated. The bench checks this against a scoreboard model of the register file.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Two-requester write-back arbiter for a small register file: one-entry
// buffers per requester, age-aware round-robin drain, registered write port.
module regfile_write_arbiter_buf #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 2
)(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  i_acc,
  input  logic                  i_drain,
  input  logic [ADDR_WIDTH-1:0] i_wr,
  input  logic [DATA_WIDTH-1:0] i_wd,
  output logic                  o_vld,
  output logic [ADDR_WIDTH-1:0] o_wr,
  output logic [DATA_WIDTH-1:0] o_wd
);
  logic                  r_vld;
  logic [ADDR_WIDTH-1:0] r_wr;
  logic [DATA_WIDTH-1:0] r_wd;

  // Accept wins over drain so a draining slot refills on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= 1'b0;
      r_wr  <= '0;
      r_wd  <= '0;
    end else if (i_acc) begin
      r_vld <= 1'b1;
      r_wr  <= i_wr;
      r_wd  <= i_wd;
    end else if (i_drain) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_wr  = r_wr;
  assign o_wd  = r_wd;
endmodule

module regfile_write_arbiter #(
  parameter  int DATA_WIDTH = 16,
  parameter  int ADDR_WIDTH = 2,
  localparam int NREGS      = 2**ADDR_WIDTH
)(
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_wr,
  input  logic [DATA_WIDTH-1:0] req0_wd,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_wr,
  input  logic [DATA_WIDTH-1:0] req1_wd,
  output logic                  req1_ready,
  output logic                  RegWrite,
  output logic [ADDR_WIDTH-1:0] WR,
  output logic [DATA_WIDTH-1:0] WD,
  output logic [1:0]            grant,
  output logic [NREGS-1:0]      pending
);
  logic [1:0]                 w_in_vld, w_vld, w_acc, w_drain, w_rdy;
  logic [1:0][ADDR_WIDTH-1:0] w_in_wr, w_bwr;
  logic [1:0][DATA_WIDTH-1:0] w_in_wd, w_bwd;
  logic                       w_contest, w_sel;

  logic                  r_alive, r_ptr, r_old1;
  logic                  r_regwrite;
  logic [ADDR_WIDTH-1:0] r_wr;
  logic [DATA_WIDTH-1:0] r_wd;
  logic [1:0]            r_grant;

  assign w_in_vld = {req1_valid, req0_valid};
  assign w_in_wr  = {req1_wr, req0_wr};
  assign w_in_wd  = {req1_wd, req0_wd};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_buf
      regfile_write_arbiter_buf #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_buf (
        .clock   (clock),
        .reset_n (reset_n),
        .i_acc   (w_acc[g]),
        .i_drain (w_drain[g]),
        .i_wr    (w_in_wr[g]),
        .i_wd    (w_in_wd[g]),
        .o_vld   (w_vld[g]),
        .o_wr    (w_bwr[g]),
        .o_wd    (w_bwd[g])
      );
      assign w_rdy[g] = r_alive & (~w_vld[g] | w_drain[g]);
      assign w_acc[g] = w_in_vld[g] & w_rdy[g];
    end
  endgenerate

  // r_old1: buffer 1 holds the older entry (only meaningful when both are full).
  // r_ptr: 0 favours req0 in a different-register contest.
  assign w_contest = &w_vld & (w_bwr[0] != w_bwr[1]);

  always_comb begin
    w_drain = w_vld;
    if (&w_vld) begin
      if (w_bwr[0] == w_bwr[1]) w_drain = r_old1 ? 2'b10 : 2'b01;
      else                      w_drain = r_ptr  ? 2'b10 : 2'b01;
    end
  end

  assign w_sel = w_drain[1];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_alive    <= 1'b0;
      r_ptr      <= 1'b0;
      r_old1     <= 1'b0;
      r_regwrite <= 1'b0;
      r_wr       <= '0;
      r_wd       <= '0;
      r_grant    <= 2'b00;
    end else begin
      r_alive <= 1'b1;
      if (w_contest) r_ptr <= w_drain[0];
      // A fresh entry is younger than a surviving one; same-edge pairs favour req0.
      if (&w_acc)                                  r_old1 <= 1'b0;
      else if (w_acc[0] & w_vld[1] & ~w_drain[1]) r_old1 <= 1'b1;
      else if (w_acc[1] & w_vld[0] & ~w_drain[0]) r_old1 <= 1'b0;
      r_regwrite <= |w_drain;
      r_grant    <= w_drain;
      if (|w_drain) begin
        r_wr <= w_bwr[w_sel];
        r_wd <= w_bwd[w_sel];
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < 2; i++)
      if (w_vld[i]) pending[w_bwr[i]] = 1'b1;
    if (r_regwrite) pending[r_wr] = 1'b1;
  end

  assign req0_ready = w_rdy[0];
  assign req1_ready = w_rdy[1];
  assign RegWrite   = r_regwrite;
  assign WR         = r_wr;
  assign WD         = r_wd;
  assign grant      = r_grant;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: a timestamp/queue reference model predicts every issued
// write; a negedge monitor compares what the arbiter actually presents.
module tb_regfile_write_arbiter;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int NR = 4;

  typedef struct {
    logic [1:0]    g;
    logic [AW-1:0] wr;
    logic [DW-1:0] wd;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_wr, req1_wr;
  logic [DW-1:0] req0_wd, req1_wd;
  logic          req0_ready, req1_ready, RegWrite;
  logic [AW-1:0] WR;
  logic [DW-1:0] WD;
  logic [1:0]    grant;
  logic [NR-1:0] pending;

  regfile_write_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_wr(req0_wr), .req0_wd(req0_wd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_wr(req1_wr), .req1_wd(req1_wd), .req1_ready(req1_ready),
    .RegWrite(RegWrite), .WR(WR), .WD(WD), .grant(grant), .pending(pending)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: each buffer is an (occupied, wr, wd, accept-cycle) record.
  logic          m_v0, m_v1, m_ptr, m_alive, m_out_v;
  logic [AW-1:0] m_wr0, m_wr1, m_out_wr;
  logic [DW-1:0] m_wd0, m_wd1;
  int            m_st0, m_st1, m_cyc, m_acc;
  exp_t          expq[$];
  logic [DW-1:0] m_rf[NR];
  logic [DW-1:0] dut_rf[NR];
  int            n_dut_wr;

  function automatic logic [1:0] m_pick();
    if (m_v0 && m_v1) begin
      if (m_wr0 == m_wr1) return (m_st1 < m_st0) ? 2'b10 : 2'b01;
      return m_ptr ? 2'b10 : 2'b01;
    end
    return {m_v1, m_v0};
  endfunction

  function automatic logic [NR-1:0] m_pending();
    logic [NR-1:0] p;
    p = '0;
    if (m_v0)    p[m_wr0]    = 1'b1;
    if (m_v1)    p[m_wr1]    = 1'b1;
    if (m_out_v) p[m_out_wr] = 1'b1;
    return p;
  endfunction

  initial begin
    m_v0 = 0; m_v1 = 0; m_ptr = 0; m_alive = 0; m_out_v = 0;
    m_wr0 = 0; m_wr1 = 0; m_wd0 = 0; m_wd1 = 0; m_out_wr = 0;
    m_st0 = 0; m_st1 = 0; m_cyc = 0; m_acc = 0;
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) begin
        m_v0 = 0; m_v1 = 0; m_ptr = 0; m_alive = 0; m_out_v = 0; m_acc = 0;
        expq.delete();
      end else begin
        logic [1:0] pk;
        logic r0, r1, contest;
        pk = m_pick();
        r0 = m_alive && (!m_v0 || pk[0]);
        r1 = m_alive && (!m_v1 || pk[1]);
        contest = m_v0 && m_v1 && (m_wr0 != m_wr1);
        m_out_v = (pk != 2'b00);
        if (m_out_v) begin
          exp_t e;
          e.g  = pk;
          e.wr = pk[0] ? m_wr0 : m_wr1;
          e.wd = pk[0] ? m_wd0 : m_wd1;
          m_out_wr = e.wr;
          expq.push_back(e);
        end
        if (contest) m_ptr = pk[0];
        if (pk[0]) m_v0 = 0;
        if (pk[1]) m_v1 = 0;
        if (req0_valid && r0) begin m_v0 = 1; m_wr0 = req0_wr; m_wd0 = req0_wd; m_st0 = m_cyc; m_acc++; end
        if (req1_valid && r1) begin m_v1 = 1; m_wr1 = req1_wr; m_wd1 = req1_wd; m_st1 = m_cyc; m_acc++; end
        m_alive = 1;
        m_cyc++;
      end
    end
  end

  // Monitor: outputs depend on registered state only, so negedge sampling is stable.
  initial begin
    n_dut_wr = 0;
    forever begin
      logic [1:0] pk;
      @(negedge clock);
      pk = m_pick();
      chk("req0_ready", req0_ready, m_alive && (!m_v0 || pk[0]));
      chk("req1_ready", req1_ready, m_alive && (!m_v1 || pk[1]));
      chk("pending", pending, m_pending());
      if (!reset_n) n_dut_wr = 0;
      chk("regwrite", RegWrite, expq.size() != 0);
      if (RegWrite === 1'b1 && expq.size() != 0) begin
        exp_t e;
        e = expq.pop_front();
        chk("grant", grant, e.g);
        chk("WR", WR, e.wr);
        chk("WD", WD, e.wd);
        m_rf[e.wr] = e.wd;
        dut_rf[WR] = WD;
        n_dut_wr++;
      end else if (RegWrite !== 1'b1) begin
        chk("grant_idle", grant, 2'b00);
        expq.delete();
      end
    end
  end

  task automatic drive(input logic v0, input logic [AW-1:0] w0, input logic [DW-1:0] d0,
                       input logic v1, input logic [AW-1:0] w1, input logic [DW-1:0] d1);
    @(negedge clock); #1;
    req0_valid = v0; req0_wr = w0; req0_wd = d0;
    req1_valid = v1; req1_wr = w1; req1_wd = d1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic rnd(input int n, input int p0, input int p1);
    for (int i = 0; i < n; i++)
      drive($urandom_range(99) < p0, AW'($urandom), DW'($urandom),
            $urandom_range(99) < p1, AW'($urandom), DW'($urandom));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_regwrite"}, RegWrite, 1'b0);
    chk({tag, "_grant"}, grant, 2'b00);
    chk({tag, "_WR"}, WR, '0);
    chk({tag, "_WD"}, WD, '0);
    chk({tag, "_pending"}, pending, '0);
    chk({tag, "_ready"}, {req1_ready, req0_ready}, 2'b00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin m_rf[i] = '0; dut_rf[i] = '0; end
    reset_n = 1'b0;
    req0_valid = 0; req0_wr = 0; req0_wd = 0;
    req1_valid = 0; req1_wr = 0; req1_wd = 0;
    #1 chk_reset_outputs("por");
    #12 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_release", {req1_ready, req0_ready}, 2'b11);

    // Single write: accept, issue next cycle, pending clears after the write edge.
    drive(1, 2'b01, 16'hAAAA, 0, 0, 0);
    @(negedge clock);
    chk("single_pending_buf", pending, 4'b0010);
    #1 req0_valid = 0;
    @(negedge clock);
    chk("single_regwrite", RegWrite, 1'b1);
    chk("single_WR", WR, 2'b01);
    chk("single_WD", WD, 16'hAAAA);
    chk("single_grant", grant, 2'b01);
    chk("single_pending_out", pending, 4'b0010);
    @(negedge clock);
    chk("single_idle", {RegWrite, pending}, 5'b0_0000);

    // Contention on different registers, twice to exercise the pointer toggle.
    drive(1, 2'b10, 16'h5555, 1, 2'b11, 16'h1234);
    idle(3);
    drive(1, 2'b10, 16'h6666, 1, 2'b11, 16'h4321);
    idle(3);

    // Same-register age: BEEF buffered first, CAFE arrives while BEEF waits.
    drive(1, 2'b10, 16'h0F0F, 1, 2'b01, 16'hBEEF);
    drive(1, 2'b01, 16'hCAFE, 0, 0, 0);
    idle(3);
    drive(1, 2'b01, 16'h1111, 1, 2'b01, 16'h2222);
    idle(3);

    // Streaming from req1 alone.
    for (int i = 0; i < 8; i++) drive(0, 0, 0, 1, AW'(i), DW'(16'h1000 + i));
    idle(3);

    // Backpressure: both valid continuously.
    rnd(40, 100, 100);
    idle(3);
    rnd(300, 60, 60);
    rnd(100, 90, 30);

    // Reset mid-stream with both buffers full.
    rnd(6, 100, 100);
    @(posedge clock); #2 reset_n = 1'b0;
    #1 chk_reset_outputs("mid");
    req0_valid = 0; req1_valid = 0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("mid_ready_after_release", {req1_ready, req0_ready}, 2'b11);
    chk("mid_pending_after_release", pending, '0);

    rnd(200, 70, 70);
    idle(5);
    chk("write_count", n_dut_wr, m_acc);
    for (int i = 0; i < NR; i++) chk($sformatf("regfile[%0d]", i), dut_rf[i], m_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
